// File: rtl/ps2_kbd_ctrl_pkg.sv
// PS/2 keyboard controller shared definitions.
// Set-2 scan-code prefixes, event layout and FSM encodings.
package ps2_kbd_ctrl_pkg;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_PAUSE   = 8'hE1;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] PAUSE_CODE = 8'h77;

    localparam int EV_W = 10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    // Bytes following E1 that make up the rest of the pause sequence
    localparam logic [2:0] SKIP_LEN = 3'd7;

    function automatic logic [EV_W-1:0] mk_ev(
        input logic       ext,
        input logic       brk,
        input logic [7:0] code
    );
        return {ext, brk, code};
    endfunction

endpackage

// File: rtl/counter.sv
// Free-running up counter with synchronous clear.
// hit flags the LIMIT-1 count; the count holds there until cleared.
module counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] cnt;

    assign hit = en && (cnt == W'(LIMIT - 1));

    // Count while enabled, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_fifo.sv
// Synchronous key-event FIFO with wrap-bit pointers.
// A pop in the same cycle as a push on a full FIFO frees the slot first.
module key_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage; cleared so the head reads zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: byte handshake, Set-2 decode,
// key-event FIFO and error/overflow/ready status.
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1_000_000,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rx_req,
    input  logic [7:0]       rx_data,
    input  logic             rx_err,
    input  logic             rx_ack,
    output logic             ev_valid,
    output logic [EV_W-1:0]  ev_data,
    input  logic             ev_pop,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [ERR_W-1:0] err_cnt,
    output logic             kbd_ready
);

    logic [2:0]      st;
    logic [2:0]      st_n;
    logic [2:0]      skip_cnt;
    logic [2:0]      skip_n;
    logic            accept;
    logic            push;
    logic [EV_W-1:0] ev;
    logic            err_inc;
    logic            rdy_set;
    logic            tmo_hit;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;

    assign accept   = rx_ack && rx_req;
    assign ev_valid = !fifo_empty;
    assign drop     = push && fifo_full && !ev_pop;

    counter #(
        .LIMIT (TIMEOUT)
    ) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr ((st == ST_IDLE) || accept),
        .en  (st != ST_IDLE),
        .hit (tmo_hit)
    );

    key_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ev),
        .pop   (ev_pop),
        .dout  (ev_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode the accepted byte; a byte beats a simultaneous timeout
    always_comb begin
        st_n    = st;
        skip_n  = skip_cnt;
        push    = 1'b0;
        ev      = '0;
        err_inc = 1'b0;
        rdy_set = 1'b0;
        if (accept) begin
            if (rx_err) begin
                st_n    = ST_IDLE;
                err_inc = 1'b1;
            end else begin
                unique case (st)
                    ST_IDLE: begin
                        if (rx_data == SC_EXT) begin
                            st_n = ST_EXT;
                        end else if (rx_data == SC_BRK) begin
                            st_n = ST_BRK;
                        end else if (rx_data == SC_PAUSE) begin
                            st_n   = ST_SKIP;
                            skip_n = SKIP_LEN;
                        end else if (rx_data == SC_BAT_OK) begin
                            rdy_set = 1'b1;
                        end else begin
                            push = 1'b1;
                            ev   = mk_ev(1'b0, 1'b0, rx_data);
                        end
                    end
                    ST_EXT: begin
                        if (rx_data == SC_BRK) begin
                            st_n = ST_EXT_BRK;
                        end else if (rx_data != SC_EXT) begin
                            push = 1'b1;
                            ev   = mk_ev(1'b1, 1'b0, rx_data);
                            st_n = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        push = 1'b1;
                        ev   = mk_ev(1'b0, 1'b1, rx_data);
                        st_n = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        push = 1'b1;
                        ev   = mk_ev(1'b1, 1'b1, rx_data);
                        st_n = ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_n = skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) begin
                            push = 1'b1;
                            ev   = mk_ev(1'b1, 1'b0, PAUSE_CODE);
                            st_n = ST_IDLE;
                        end
                    end
                    default: begin
                        st_n = ST_IDLE;
                    end
                endcase
            end
        end else if (tmo_hit) begin
            st_n    = ST_IDLE;
            err_inc = 1'b1;
        end
    end

    // FSM and pause-skip state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            st       <= st_n;
            skip_cnt <= skip_n;
        end
    end

    // Always ready for the next byte once out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_req <= 1'b0;
        else     rx_req <= 1'b1;
    end

    // Sticky overflow; a new drop wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

    // Saturating error counter and sticky keyboard-ready flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt   <= '0;
            kbd_ready <= 1'b0;
        end else begin
            if (err_inc && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            if (rdy_set)                kbd_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Testbench for ps2_kbd_ctrl: directed scan-code cases then random
// traffic, all checked against a byte-level behavioural model.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 20;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_req;
    logic [7:0]       rx_data;
    logic             rx_err;
    logic             rx_ack;
    logic             ev_valid;
    logic [9:0]       ev_data;
    logic             ev_pop;
    logic             ovf;
    logic             ovf_clr;
    logic [ERR_W-1:0] err_cnt;
    logic             kbd_ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state: pending prefix flags, remaining pause bytes, queue
    logic [9:0] mq[$];
    bit         m_ext;
    bit         m_brk;
    int         m_skip;
    int         m_last;
    bit         m_ovf;
    bit         m_rdy;
    int         m_err;

    ps2_kbd_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .ERR_W   (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_req    (rx_req),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .rx_ack    (rx_ack),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ev_pop    (ev_pop),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .err_cnt   (err_cnt),
        .kbd_ready (kbd_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
        m_last = 0;
        m_ovf  = 0;
        m_rdy  = 0;
        m_err  = 0;
    endfunction

    function automatic void m_abort(input bit count_err);
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
        if (count_err && m_err < ERR_MAX) m_err++;
    endfunction

    // A prefix left waiting TIMEOUT cycles is abandoned as an error
    function automatic void m_settle(input int t);
        if ((m_ext || m_brk || m_skip > 0) && (m_last + TIMEOUT <= t))
            m_abort(1);
    endfunction

    function automatic void m_push(input bit x, input bit b,
                                   input logic [7:0] code);
        if (mq.size() < DEPTH) mq.push_back({x, b, code});
        else                   m_ovf = 1;
    endfunction

    function automatic void m_byte(input logic [7:0] b, input bit e,
                                   input bit pop, input int t);
        if (pop && mq.size() > 0) void'(mq.pop_front());
        m_last = t;
        if (e) begin
            m_abort(1);
        end else if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) m_push(1, 0, 8'h77);
        end else if (m_brk) begin
            m_push(m_ext, 1, b);
            m_abort(0);
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                m_push(1, 0, b);
                m_abort(0);
            end
        end else begin
            case (b)
                8'hE0:   m_ext = 1;
                8'hF0:   m_brk = 1;
                8'hE1:   m_skip = 7;
                8'hAA:   m_rdy = 1;
                default: m_push(0, 0, b);
            endcase
        end
    endfunction

    task automatic send(input logic [7:0] b, input bit e, input bit pop);
        int w = 0;
        @(negedge clk);
        while (!rx_req && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!rx_req) chk("rx_req_wait", 32'(rx_req), 32'd1);
        rx_data = b;
        rx_err  = e;
        rx_ack  = 1'b1;
        ev_pop  = pop;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
        rx_err = 1'b0;
        ev_pop = 1'b0;
        m_settle(cyc - 1);
        m_byte(b, e, pop, cyc);
    endtask

    task automatic pop_one();
        @(negedge clk);
        ev_pop = 1'b1;
        @(posedge clk);
        #1;
        ev_pop = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clr_ovf();
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        m_ovf = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        m_settle(cyc);
    endtask

    task automatic check_all(input string tag);
        m_settle(cyc);
        chk({tag, ".ev_valid"}, 32'(ev_valid), 32'(mq.size() > 0));
        if (mq.size() > 0)
            chk({tag, ".ev_data"}, 32'(ev_data), 32'(mq[0]));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
        chk({tag, ".kbd_ready"}, 32'(kbd_ready), 32'(m_rdy));
        chk({tag, ".rx_req"}, 32'(rx_req), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = mq.size();
        for (int i = 0; i < n; i++) begin
            check_all(tag);
            pop_one();
        end
        check_all({tag, ".empty"});
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".rx_req"}, 32'(rx_req), 32'd0);
        chk({tag, ".ev_valid"}, 32'(ev_valid), 32'd0);
        chk({tag, ".ev_data"}, 32'(ev_data), 32'd0);
        chk({tag, ".ovf"}, 32'(ovf), 32'd0);
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, ".kbd_ready"}, 32'(kbd_ready), 32'd0);
    endtask

    initial begin
        logic [7:0] pool [4];
        logic [7:0] b;
        int         r;
        pool[0] = 8'hE0;
        pool[1] = 8'hF0;
        pool[2] = 8'hE1;
        pool[3] = 8'hAA;

        rst     = 1'b1;
        rx_data = '0;
        rx_err  = 1'b0;
        rx_ack  = 1'b0;
        ev_pop  = 1'b0;
        ovf_clr = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Make then break of the same key
        send(8'h1C, 0, 0);
        chk("latency.ev_valid", 32'(ev_valid), 32'd1);
        chk("latency.ev_data", 32'(ev_data), 32'h01C);
        send(8'hF0, 0, 0);
        send(8'h1C, 0, 0);
        chk("make_brk.count", 32'(mq.size()), 32'd2);
        drain("make_brk");

        // Extended make and extended break
        send(8'hE0, 0, 0);
        send(8'h75, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hF0, 0, 0);
        send(8'h75, 0, 0);
        drain("ext");

        // Pause: E1 plus seven bytes yields one event
        send(8'hE1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            send(8'($urandom_range(0, 255)), 0, 0);
            check_all("pause");
        end
        chk("pause.ev_data", 32'(ev_data), 32'h277);
        drain("pause");

        // Timeout after an extended prefix
        send(8'hE0, 0, 0);
        idle(TIMEOUT + 2);
        chk("tmo.err_cnt", 32'(err_cnt), 32'd1);
        send(8'h1C, 0, 0);
        chk("tmo.ev_data", 32'(ev_data), 32'h01C);
        drain("tmo");

        // Parity error inside a break, then BAT-OK
        send(8'hF0, 0, 0);
        send(8'h55, 1, 0);
        send(8'h1C, 0, 0);
        chk("perr.err_cnt", 32'(err_cnt), 32'd2);
        drain("perr");
        send(8'hAA, 0, 0);
        chk("bat.kbd_ready", 32'(kbd_ready), 32'd1);
        chk("bat.ev_valid", 32'(ev_valid), 32'd0);

        // Overflow, clear, then pop rescuing the full-FIFO push
        for (int i = 0; i <= DEPTH; i++) send(8'(8'h10 + i), 0, 0);
        chk("ovf.set", 32'(ovf), 32'd1);
        drain("ovf");
        clr_ovf();
        check_all("ovf_clr");
        for (int i = 0; i < DEPTH; i++) send(8'(8'h30 + i), 0, 0);
        send(8'h3F, 0, 1);
        chk("ovf.rescue", 32'(ovf), 32'd0);
        drain("rescue");

        // Pop on empty is ignored
        pop_one();
        check_all("pop_empty");

        // Error counter saturates
        for (int i = 0; i < ERR_MAX + 3; i++) send(8'h00, 1, 0);
        chk("sat.err_cnt", 32'(err_cnt), 32'(ERR_MAX));
        check_all("sat");

        // Reset in the middle of an extended break
        send(8'h21, 0, 0);
        send(8'hE0, 0, 0);
        send(8'hF0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        rst = 1'b0;
        m_reset();
        send(8'h75, 0, 0);
        chk("post_rst.ev_data", 32'(ev_data), 32'h075);
        drain("post_rst");

        // Random traffic
        for (int s = 0; s < 400; s++) begin
            r = $urandom_range(0, 11);
            if (r < 2) begin
                pop_one();
            end else if (r < 4) begin
                if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
                else idle($urandom_range(TIMEOUT - 3, TIMEOUT + 1));
            end else if (r == 4) begin
                clr_ovf();
            end else begin
                if ($urandom_range(0, 1) == 0)
                    b = pool[$urandom_range(0, 3)];
                else
                    b = 8'($urandom_range(0, 255));
                send(b, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 3) == 0);
            end
            check_all("rand");
        end
        drain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
